// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the pipelined Gray/binary converter.
// The optional adjacency check is enabled by GRAY_CONV_ADJ_CHECK_EN.
package gray_conv_pkg;

    typedef enum logic {
        MODE_G2B = 1'b0,
        MODE_B2G = 1'b1
    } mode_e;

    localparam int unsigned MAX_WIDTH = 32;

    // Bits resolved per stage for the Gray-to-binary prefix chain (MSB-first).
    function automatic int unsigned chunk_len(input int unsigned width, input int unsigned stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// One pipeline stage: valid/ready register plus the slice [HI:LO] of the
// Gray-to-binary prefix chain; the first stage also does the full binary-to-Gray.
module gray_conv_stage
    import gray_conv_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int          HI    = 7,
    parameter int          LO    = 4,
    parameter bit          FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  mode_e            i_mode,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output mode_e            o_mode,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    mode_e            r_mode;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_res;

    // Bits above HI arrive already resolved, so bit HI can chain off w_res[HI+1].
    always_comb begin
        w_res = i_data;
        if (i_mode == MODE_B2G) begin
            if (FIRST) begin
                w_res = i_data ^ (i_data >> 1);
            end
        end else begin
            for (int unsigned j = 0; j + 1 < WIDTH; j++) begin
                if (int'(WIDTH - 2 - j) <= HI && int'(WIDTH - 2 - j) >= LO) begin
                    w_res[WIDTH-2-j] = i_data[WIDTH-2-j] ^ w_res[WIDTH-1-j];
                end
            end
        end
    end

    assign o_ready = ~r_valid | i_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_mode  <= MODE_G2B;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_mode <= i_mode;
                r_data <= w_res;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_data  = r_data;

endmodule

// File: rtl/gray_conv_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready backpressure.
// Define GRAY_CONV_ADJ_CHECK_EN to add the sticky adj_err adjacency check.
module gray_conv_pipe
    import gray_conv_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data
`ifdef GRAY_CONV_ADJ_CHECK_EN
    ,
    output logic             adj_err
`endif
);

    localparam int unsigned CHUNK = chunk_len(WIDTH, STAGES);

    logic             w_valid [STAGES+1];
    logic             w_ready [STAGES+1];
    mode_e            w_mode  [STAGES+1];
    logic [WIDTH-1:0] w_data  [STAGES+1];

    assign w_valid[0]      = in_valid;
    assign w_mode[0]       = mode_e'(in_mode);
    assign w_data[0]       = in_data;
    assign w_ready[STAGES] = out_ready;
    assign in_ready        = w_ready[0];

    // Trailing stages whose slice falls below bit 0 simply carry the word.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        gray_conv_stage #(
            .WIDTH (WIDTH),
            .HI    (int'(WIDTH) - 1 - k * int'(CHUNK)),
            .LO    (int'(WIDTH) - (k + 1) * int'(CHUNK)),
            .FIRST (k == 0)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_valid[k]),
            .o_ready (w_ready[k]),
            .i_mode  (w_mode[k]),
            .i_data  (w_data[k]),
            .o_valid (w_valid[k+1]),
            .i_ready (w_ready[k+1]),
            .o_mode  (w_mode[k+1]),
            .o_data  (w_data[k+1])
        );
    end

    assign out_valid = w_valid[STAGES];
    assign out_mode  = logic'(w_mode[STAGES]);
    assign out_data  = w_data[STAGES];

`ifdef GRAY_CONV_ADJ_CHECK_EN
    logic [WIDTH-1:0]     r_prev;
    logic                 r_seen;
    logic                 r_adj_err;
    logic                 w_g_hs;
    logic [MAX_WIDTH-1:0] w_diff;

    assign w_g_hs = in_valid & in_ready & (mode_e'(in_mode) == MODE_G2B);
    assign w_diff = MAX_WIDTH'(r_prev ^ in_data);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev    <= '0;
            r_seen    <= 1'b0;
            r_adj_err <= 1'b0;
        end else if (w_g_hs) begin
            r_prev <= in_data;
            r_seen <= 1'b1;
            if (r_seen && popcount(w_diff) > 1) begin
                r_adj_err <= 1'b1;
            end
        end
    end

    assign adj_err = r_adj_err;
`endif

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Self-checking bench: vector table with exact latency checks plus a scoreboard
// on an 8-bit/2-stage and a 13-bit/5-stage instance.
module tb_gray_conv_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
    logic [7:0]  in_data, out_data;
    logic        a_valid, a_ready, a_mode, a_ovalid, a_oready, a_omode;
    logic [12:0] a_data, a_odata;
`ifdef GRAY_CONV_ADJ_CHECK_EN
    logic        adj_err, a_adj_err;
`endif

    gray_conv_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data)
`ifdef GRAY_CONV_ADJ_CHECK_EN
        , .adj_err(adj_err)
`endif
    );

    gray_conv_pipe #(.WIDTH(13), .STAGES(5)) dut13 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_valid), .in_ready(a_ready), .in_mode(a_mode), .in_data(a_data),
        .out_valid(a_ovalid), .out_ready(a_oready), .out_mode(a_omode), .out_data(a_odata)
`ifdef GRAY_CONV_ADJ_CHECK_EN
        , .adj_err(a_adj_err)
`endif
    );

    typedef struct {
        logic        mode;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic       mode;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          n_out8 = 0;
    int          n_out13 = 0;
    exp_t        q8[$];
    exp_t        q13[$];
    logic        hold8 = 1'b0, hold13 = 1'b0;
    logic [31:0] hd8, hd13;
    logic        hm8, hm13;
    vec_t        vecs[8];

    function automatic logic [31:0] model(input logic m, input logic [31:0] d, input int w);
        logic [31:0] b;
        b = '0;
        if (m) return d ^ (d >> 1);
        b[w-1] = d[w-1];
        for (int i = w - 2; i >= 0; i--) b[i] = d[i] ^ b[i+1];
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (!rst_n) begin
            q8.delete();
            q13.delete();
            hold8  = 1'b0;
            hold13 = 1'b0;
        end else begin
            if (hold8) begin
                chk("hold8_valid", out_valid, 1);
                chk("hold8_data", out_data, hd8);
                chk("hold8_mode", out_mode, hm8);
            end
            if (out_valid && out_ready) begin
                if (q8.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out8_unexpected: got 0x%0h expected no word at %0t", out_data, $time);
                end else begin
                    e = q8.pop_front();
                    chk("out8_data", out_data, e.data);
                    chk("out8_mode", out_mode, e.mode);
                end
                n_out8++;
            end
            hold8 = out_valid && !out_ready;
            hd8   = {24'b0, out_data};
            hm8   = out_mode;
            if (in_valid && in_ready) q8.push_back('{in_mode, model(in_mode, {24'b0, in_data}, 8)});

            if (hold13) begin
                chk("hold13_valid", a_ovalid, 1);
                chk("hold13_data", a_odata, hd13);
                chk("hold13_mode", a_omode, hm13);
            end
            if (a_ovalid && a_oready) begin
                if (q13.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out13_unexpected: got 0x%0h expected no word at %0t", a_odata, $time);
                end else begin
                    e = q13.pop_front();
                    chk("out13_data", a_odata, e.data);
                    chk("out13_mode", a_omode, e.mode);
                end
                n_out13++;
            end
            hold13 = a_ovalid && !a_oready;
            hd13   = {19'b0, a_odata};
            hm13   = a_omode;
            if (a_valid && a_ready) q13.push_back('{a_mode, model(a_mode, {19'b0, a_data}, 13)});
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic m, input logic [7:0] d);
        logic hs;
        hs       = 1'b0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        for (int t = 0; t < 50 && !hs; t++) begin
            @(negedge clk);
            hs = in_ready;
            cyc();
        end
        if (!hs) begin
            total++; bad++;
            $display("FAIL send8_timeout: got no handshake expected one for 0x%0h", d);
        end
    endtask

    initial begin
        int n0;
        vecs[0] = '{1'b0, 8'hC5, 8'h86};
        vecs[1] = '{1'b1, 8'h86, 8'hC5};
        vecs[2] = '{1'b0, 8'h00, 8'h00};
        vecs[3] = '{1'b0, 8'hFF, 8'hAA};
        vecs[4] = '{1'b1, 8'hFF, 8'h80};
        vecs[5] = '{1'b0, 8'h80, 8'hFF};
        vecs[6] = '{1'b1, 8'hAA, 8'hFF};
        vecs[7] = '{1'b0, 8'h01, 8'h01};

        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
        a_valid = 1'b0; a_mode = 1'b0; a_data = '0; a_oready = 1'b1;

        fork
            forever begin
                @(negedge clk);
                mon();
            end
        join_none

        repeat (2) cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst13_out_valid", a_ovalid, 0);
`ifdef GRAY_CONV_ADJ_CHECK_EN
        chk("rst_adj_err", adj_err, 0);
        chk("rst13_adj_err", a_adj_err, 0);
`endif
        rst_n = 1'b1;
        cyc();
        chk("post_rst_in_ready", in_ready, 1);

        // Vector table with exact two-cycle latency.
        foreach (vecs[i]) begin
            in_valid = 1'b1; in_mode = vecs[i].mode; in_data = vecs[i].din;
            @(negedge clk);
            chk("vec_in_ready", in_ready, 1);
            cyc();
            in_valid = 1'b0;
            chk("vec_lat1_valid", out_valid, 0);
            cyc();
            chk("vec_lat2_valid", out_valid, 1);
            chk("vec_data", out_data, {24'b0, vecs[i].dout});
            chk("vec_mode", out_mode, vecs[i].mode);
            cyc();
        end

        // Full sweep, both modes, back-to-back.
        n0 = n_out8;
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 256; v++) begin
                in_valid = 1'b1; in_mode = m[0]; in_data = v[7:0];
                @(negedge clk);
                chk("sweep_in_ready", in_ready, 1);
                cyc();
            end
        end
        in_valid = 1'b0;
        repeat (4) cyc();
        chk("sweep_count", n_out8 - n0, 512);
        chk("sweep_drained", q8.size(), 0);

        // Backpressure: pipeline fills after two accepts, then drains exactly three words.
        out_ready = 1'b0;
        n0 = n_out8;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h11;
        @(negedge clk); chk("bp_accept0", in_ready, 1); cyc();
        in_mode = 1'b1; in_data = 8'h22;
        @(negedge clk); chk("bp_accept1", in_ready, 1); cyc();
        in_mode = 1'b0; in_data = 8'h33;
        repeat (3) begin
            @(negedge clk);
            chk("bp_full_in_ready", in_ready, 0);
            chk("bp_full_out_valid", out_valid, 1);
            cyc();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_full_pass_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        repeat (5) cyc();
        chk("bp_count", n_out8 - n0, 3);
        chk("bp_drained", q8.size(), 0);

        // Reset with a full pipeline discards everything.
        out_ready = 1'b0;
        send8(1'b0, 8'h5A);
        send8(1'b1, 8'h3C);
        in_valid = 1'b0;
        chk("rstmid_full", out_valid, 1);
        rst_n = 1'b0;
        cyc();
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_out_data", out_data, 0);
        chk("rstmid_in_ready", in_ready, 1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            cyc();
            chk("rstmid_no_stale", out_valid, 0);
        end

`ifdef GRAY_CONV_ADJ_CHECK_EN
        send8(1'b0, 8'h00); chk("adj_00", adj_err, 0);
        send8(1'b0, 8'h01); chk("adj_01", adj_err, 0);
        send8(1'b0, 8'h01); chk("adj_01_eq", adj_err, 0);
        send8(1'b1, 8'hF0); chk("adj_mode1_ignored", adj_err, 0);
        send8(1'b0, 8'h03); chk("adj_03", adj_err, 0);
        send8(1'b0, 8'h0C); chk("adj_0C", adj_err, 1);
        send8(1'b0, 8'h0D); chk("adj_sticky", adj_err, 1);
        in_valid = 1'b0;
        repeat (4) cyc();
        chk("adj_sticky_idle", adj_err, 1);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        chk("adj_cleared", adj_err, 0);
        repeat (2) cyc();
`endif

        // Random traffic on the 13-bit / 5-stage instance (short last chunk).
        for (int c = 0; c < 400; c++) begin
            a_valid  = ($urandom_range(0, 3) != 0);
            a_mode   = $urandom_range(0, 1) != 0;
            a_data   = 13'($urandom);
            a_oready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        a_valid  = 1'b0;
        a_oready = 1'b1;
        repeat (10) cyc();
        chk("rand13_drained", q13.size(), 0);
        chk("rand13_outputs_seen", n_out13 > 100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
